// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write bypass and busy scoreboard
// Two write ports (port 1 wins on address clash), N_READ combinational read ports.
module regfile_mp #(
  parameter int A_WIDTH  = 5,
  parameter int D_WIDTH  = 32,
  parameter int N_READ   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        WE0,
  input  logic [A_WIDTH-1:0]          AD_W0,
  input  logic [D_WIDTH-1:0]          WD0,
  input  logic                        WE1,
  input  logic [A_WIDTH-1:0]          AD_W1,
  input  logic [D_WIDTH-1:0]          WD1,
  input  logic [N_READ*A_WIDTH-1:0]   AD_R,
  output logic [N_READ*D_WIDTH-1:0]   RD,
  output logic [N_READ-1:0]           RD_BUSY,
  input  logic                        BUSY_SET,
  input  logic [A_WIDTH-1:0]          AD_BUSY,
  output logic [(2**A_WIDTH)-1:0]     BUSY,
  output logic [D_WIDTH-1:0]          a0
);

  localparam int N_REGS = 2**A_WIDTH;

  logic [N_REGS-1:0][D_WIDTH-1:0] mem_q;
  logic [N_REGS-1:0]              busy_q;
  logic [N_READ-1:0][D_WIDTH-1:0] rd_d;
  logic [N_READ-1:0]              rd_busy_d;
  logic                           wen0;
  logic                           wen1;

  // Writes are blocked while reset is held, which also keeps the bypass from leaking data.
  assign wen0 = WE0 && rst_n;
  assign wen1 = WE1 && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      for (int r = 0; r < N_REGS; r++) begin
        if (!(ZERO_REG != 0 && r == 0)) begin
          if (wen1 && AD_W1 == A_WIDTH'(r))
            mem_q[r] <= WD1;
          else if (wen0 && AD_W0 == A_WIDTH'(r))
            mem_q[r] <= WD0;
          // A new producer issued this cycle supersedes the one retiring.
          if (BUSY_SET && AD_BUSY == A_WIDTH'(r))
            busy_q[r] <= 1'b1;
          else if ((wen1 && AD_W1 == A_WIDTH'(r)) || (wen0 && AD_W0 == A_WIDTH'(r)))
            busy_q[r] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    logic [A_WIDTH-1:0] addr;
    addr      = '0;
    rd_d      = '0;
    rd_busy_d = '0;
    for (int k = 0; k < N_READ; k++) begin
      addr         = AD_R[k*A_WIDTH +: A_WIDTH];
      rd_d[k]      = mem_q[addr];
      rd_busy_d[k] = busy_q[addr];
      if (BYPASS != 0) begin
        if (wen1 && AD_W1 == addr) begin
          rd_d[k]      = WD1;
          rd_busy_d[k] = 1'b0;
        end else if (wen0 && AD_W0 == addr) begin
          rd_d[k]      = WD0;
          rd_busy_d[k] = 1'b0;
        end
      end
      if (ZERO_REG != 0 && addr == '0) begin
        rd_d[k]      = '0;
        rd_busy_d[k] = 1'b0;
      end
    end
  end

  assign RD      = rd_d;
  assign RD_BUSY = rd_busy_d;
  assign BUSY    = busy_q;

  generate
    if (N_REGS > 10) begin : g_a0
      assign a0 = mem_q[10];
    end else begin : g_no_a0
      assign a0 = '0;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (bypass and non-bypass instances)
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we0, we1, busy_set;
  logic [4:0]  adw0, adw1, ad_busy;
  logic [31:0] wd0, wd1;
  logic [9:0]  ad_r;
  logic [63:0] rd, rd_nb;
  logic [1:0]  rdb, rdb_nb;
  logic [31:0] busy, busy_nb;
  logic [31:0] a0, a0_nb;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_mem [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .WE0(we0), .AD_W0(adw0), .WD0(wd0),
    .WE1(we1), .AD_W1(adw1), .WD1(wd1),
    .AD_R(ad_r), .RD(rd), .RD_BUSY(rdb),
    .BUSY_SET(busy_set), .AD_BUSY(ad_busy), .BUSY(busy), .a0(a0)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .WE0(we0), .AD_W0(adw0), .WD0(wd0),
    .WE1(we1), .AD_W1(adw1), .WD1(wd1),
    .AD_R(ad_r), .RD(rd_nb), .RD_BUSY(rdb_nb),
    .BUSY_SET(busy_set), .AD_BUSY(ad_busy), .BUSY(busy_nb), .a0(a0_nb)
  );

  function automatic logic [31:0] exp_rd(input int a, input bit byp);
    if (!rst_n || a == 0) return 32'h0;
    if (byp && we1 && adw1 == 5'(a)) return wd1;
    if (byp && we0 && adw0 == 5'(a)) return wd0;
    return m_mem[a];
  endfunction

  function automatic logic exp_rdb(input int a, input bit byp);
    if (!rst_n || a == 0) return 1'b0;
    if (byp && ((we1 && adw1 == 5'(a)) || (we0 && adw0 == 5'(a)))) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [31:0] exp_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic idle();
    we0 = 0; we1 = 0; busy_set = 0;
    adw0 = 0; adw1 = 0; ad_busy = 0;
    wd0 = 0; wd1 = 0;
  endtask

  // Advances one clock edge and applies the architectural write/scoreboard rules to the model.
  task automatic tick();
    logic [31:0] nm [32];
    bit          nb [32];
    for (int i = 0; i < 32; i++) begin
      nm[i] = m_mem[i];
      nb[i] = m_busy[i];
    end
    if (rst_n) begin
      if (we0 && adw0 != 0) nm[adw0] = wd0;
      if (we1 && adw1 != 0) nm[adw1] = wd1;
      if (we0) nb[adw0] = 0;
      if (we1) nb[adw1] = 0;
      if (busy_set && ad_busy != 0) nb[ad_busy] = 1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = rst_n ? nm[i] : 32'h0;
      m_busy[i] = rst_n ? nb[i] : 1'b0;
    end
  endtask

  task automatic test_reset();
    we0 = 1; adw0 = 10; wd0 = 32'h1234_5678;
    we1 = 1; adw1 = 4;  wd1 = 32'hCAFE_F00D;
    busy_set = 1; ad_busy = 9;
    ad_r = {5'd4, 5'd10};
    tick();
    tick();
    checks++;
    if (rd !== 64'h0 || rd_nb !== 64'h0) begin
      failures++;
      $display("FAIL reset_rd: got %h / %h, expected 0", rd, rd_nb);
    end
    checks++;
    if (busy !== 32'h0 || busy_nb !== 32'h0 || rdb !== 2'b0) begin
      failures++;
      $display("FAIL reset_busy: got %h / %h rdb %b, expected 0", busy, busy_nb, rdb);
    end
    checks++;
    if (a0 !== 32'h0 || a0_nb !== 32'h0) begin
      failures++;
      $display("FAIL reset_a0: got %h / %h, expected 0", a0, a0_nb);
    end
    idle();
    rst_n = 1;
    tick();
    checks++;
    if (rd !== {32'h0, 32'h0} || a0 !== 32'h0 || busy !== 32'h0) begin
      failures++;
      $display("FAIL reset_no_write: rd %h a0 %h busy %h, expected all 0", rd, a0, busy);
    end
  endtask

  task automatic test_basic_write();
    we0 = 1; adw0 = 10; wd0 = 32'hDEAD_BEEF;
    tick();
    idle();
    ad_r = {5'd0, 5'd10};
    #1;
    checks++;
    if (rd[31:0] !== 32'hDEAD_BEEF || rd_nb[31:0] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL basic_rd0: got %h / %h, expected deadbeef", rd[31:0], rd_nb[31:0]);
    end
    checks++;
    if (a0 !== 32'hDEAD_BEEF || a0_nb !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL basic_a0: got %h / %h, expected deadbeef", a0, a0_nb);
    end
  endtask

  task automatic test_bypass_conflict();
    we0 = 1; adw0 = 5; wd0 = 32'h11;
    we1 = 1; adw1 = 5; wd1 = 32'h22;
    ad_r = {5'd5, 5'd5};
    #1;
    checks++;
    if (rd !== {32'h22, 32'h22}) begin
      failures++;
      $display("FAIL bypass_conflict_rd: got %h, expected %h", rd, {32'h22, 32'h22});
    end
    checks++;
    if (rd_nb !== {32'h0, 32'h0}) begin
      failures++;
      $display("FAIL nobypass_old_rd: got %h, expected 0", rd_nb);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd !== {32'h22, 32'h22} || rd_nb !== {32'h22, 32'h22}) begin
      failures++;
      $display("FAIL conflict_stored: got %h / %h, expected 22 in both ports", rd, rd_nb);
    end
  endtask

  task automatic test_zero_reg();
    we1 = 1; adw1 = 0; wd1 = 32'hFFFF_FFFF;
    busy_set = 1; ad_busy = 0;
    ad_r = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd !== 64'h0 || rdb !== 2'b0) begin
      failures++;
      $display("FAIL zero_bypass: rd %h rdb %b, expected 0", rd, rdb);
    end
    tick();
    idle();
    #1;
    checks++;
    if (busy[0] !== 1'b0 || busy_nb[0] !== 1'b0 || rd !== 64'h0 || rd_nb !== 64'h0) begin
      failures++;
      $display("FAIL zero_stored: busy0 %b rd %h, expected 0", busy[0], rd);
    end
  endtask

  task automatic test_scoreboard();
    busy_set = 1; ad_busy = 7;
    ad_r = {5'd7, 5'd0};
    tick();
    idle();
    #1;
    checks++;
    if (busy[7] !== 1'b1 || rdb[1] !== 1'b1) begin
      failures++;
      $display("FAIL sb_set: busy7 %b rdb1 %b, expected 1 1", busy[7], rdb[1]);
    end
    tick();
    we1 = 1; adw1 = 7; wd1 = 32'h5;
    #1;
    checks++;
    if (rdb[1] !== 1'b0 || rd[63:32] !== 32'h5) begin
      failures++;
      $display("FAIL sb_bypass: rdb1 %b rd1 %h, expected 0 5", rdb[1], rd[63:32]);
    end
    checks++;
    if (rdb_nb[1] !== 1'b1) begin
      failures++;
      $display("FAIL sb_nobypass_busy: rdb1 %b, expected 1", rdb_nb[1]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (busy[7] !== 1'b0 || busy_nb[7] !== 1'b0) begin
      failures++;
      $display("FAIL sb_clear: busy7 %b / %b, expected 0", busy[7], busy_nb[7]);
    end
  endtask

  task automatic test_set_clear_collision();
    we0 = 1; adw0 = 3; wd0 = 32'h0000_0ABC;
    busy_set = 1; ad_busy = 3;
    tick();
    idle();
    ad_r = {5'd0, 5'd3};
    #1;
    checks++;
    if (busy[3] !== 1'b1 || rd[31:0] !== 32'h0ABC) begin
      failures++;
      $display("FAIL collision: busy3 %b rd0 %h, expected 1 00000abc", busy[3], rd[31:0]);
    end
    #1;
    rst_n = 0;
    #1;
    checks++;
    if (busy !== 32'h0 || busy_nb !== 32'h0 || rd !== 64'h0) begin
      failures++;
      $display("FAIL async_reset: busy %h rd %h, expected 0", busy, rd);
    end
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 0;
      m_busy[i] = 0;
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] eb;
    for (int n = 0; n < 300; n++) begin
      we0 = 1'($urandom);  adw0 = 5'($urandom_range(0, 11)); wd0 = $urandom;
      we1 = 1'($urandom);  adw1 = 5'($urandom_range(0, 11)); wd1 = $urandom;
      busy_set = 1'($urandom_range(0, 2) == 0); ad_busy = 5'($urandom_range(0, 11));
      ad_r = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rd[k*32 +: 32] !== exp_rd(int'(ad_r[k*5 +: 5]), 1'b1) ||
            rd_nb[k*32 +: 32] !== exp_rd(int'(ad_r[k*5 +: 5]), 1'b0)) begin
          failures++;
          $display("FAIL rand_rd%0d iter %0d: got %h / %h, expected %h / %h", k, n,
                   rd[k*32 +: 32], rd_nb[k*32 +: 32],
                   exp_rd(int'(ad_r[k*5 +: 5]), 1'b1), exp_rd(int'(ad_r[k*5 +: 5]), 1'b0));
        end
        checks++;
        if (rdb[k] !== exp_rdb(int'(ad_r[k*5 +: 5]), 1'b1) ||
            rdb_nb[k] !== exp_rdb(int'(ad_r[k*5 +: 5]), 1'b0)) begin
          failures++;
          $display("FAIL rand_rdbusy%0d iter %0d: got %b / %b, expected %b / %b", k, n,
                   rdb[k], rdb_nb[k],
                   exp_rdb(int'(ad_r[k*5 +: 5]), 1'b1), exp_rdb(int'(ad_r[k*5 +: 5]), 1'b0));
        end
      end
      tick();
      eb = exp_busy_vec();
      checks++;
      if (busy !== eb || busy_nb !== eb) begin
        failures++;
        $display("FAIL rand_busy iter %0d: got %h / %h, expected %h", n, busy, busy_nb, eb);
      end
      checks++;
      if (a0 !== m_mem[10] || a0_nb !== m_mem[10]) begin
        failures++;
        $display("FAIL rand_a0 iter %0d: got %h / %h, expected %h", n, a0, a0_nb, m_mem[10]);
      end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 0;
      m_busy[i] = 0;
    end
    idle();
    ad_r = 0;
    rst_n = 1;
    #1;
    rst_n = 0;
    test_reset();
    test_basic_write();
    test_bypass_conflict();
    test_zero_reg();
    test_scoreboard();
    test_set_clear_collision();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the RV32 core datapath; successor to the single-write, two-read register file.
- Provides N_READ combinational read ports and two synchronous write ports: port 0 for the ALU/writeback path, port 1 for the late/multi-cycle path (load, divide).
- Optional write-to-read bypass and a per-register busy scoreboard, so decode can detect pending producers and stall.
- Sits between decode (reads, scoreboard query) and writeback (writes).

Parameters:
- A_WIDTH, 5, register address width; the block holds 2**A_WIDTH registers.
- D_WIDTH, 32, register data width.
- N_READ, 2, number of read ports (1..4).
- BYPASS, 1, if 1, a same-cycle write is forwarded to matching read ports.
- ZERO_REG, 1, if 1, register 0 reads as zero, ignores writes, and is never busy.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- WE0  in  1  write enable, port 0.
- AD_W0  in  A_WIDTH  write address, port 0.
- WD0  in  D_WIDTH  write data, port 0.
- WE1  in  1  write enable, port 1.
- AD_W1  in  A_WIDTH  write address, port 1.
- WD1  in  D_WIDTH  write data, port 1.
- AD_R  in  N_READ*A_WIDTH  read addresses; port k occupies bits [k*A_WIDTH +: A_WIDTH].
- RD  out  N_READ*D_WIDTH  read data, packed the same way as AD_R.
- RD_BUSY  out  N_READ  bit k = 1 when the register addressed by read port k is busy.
- BUSY_SET  in  1  marks register AD_BUSY as pending (issued to a long-latency unit).
- AD_BUSY  in  A_WIDTH  scoreboard set address.
- BUSY  out  2**A_WIDTH  scoreboard vector, one bit per register.
- a0  out  D_WIDTH  contents of register 10, for debug/testbench.

Behaviour:
- Reset: the single clock is clk; reset is asynchronous and active-low on rst_n.
  - While rst_n = 0, all registers and all BUSY bits are cleared to 0 immediately, without waiting for a clock edge.
  - With the array clear, RD, RD_BUSY and a0 all read 0 during reset.
  - Writes and BUSY_SET are ignored while rst_n = 0.
- Storage: on the clk rising edge, register AD_Wp <= WDp whenever WEp = 1. Write latency is 1 cycle.
- Write conflict: if WE0 = WE1 = 1 and AD_W0 = AD_W1, port 1 wins and WD0 is discarded.
- Zero register (ZERO_REG = 1):
  - Writes to address 0 are dropped.
  - RD for address 0 is always 0.
  - BUSY[0] is always 0, and RD_BUSY for address 0 is 0.
- Reads are combinational (0-cycle), evaluated in this priority order:
  - if ZERO_REG and the address is 0, the result is 0;
  - else, if BYPASS and WE1 is set with a matching address, the result is WD1;
  - else, if BYPASS and WE0 is set with a matching address, the result is WD0;
  - else, the result is the stored value.
- With BYPASS = 0, a read returns the old value until the edge after the write.
- Scoreboard, evaluated per register r at each clk edge:
  - set  = BUSY_SET && AD_BUSY == r;
  - clr  = (WE0 && AD_W0 == r) || (WE1 && AD_W1 == r);
  - BUSY[r] <= set ? 1 : (clr ? 0 : BUSY[r]).
- Scoreboard rules:
  - When set and clear hit the same register in the same cycle, set wins (a new producer supersedes the retiring one).
  - A write to a register that is not busy is legal and leaves BUSY at 0.
- RD_BUSY[k] = BUSY[AD_R[k]], combinational from the registered vector. With BYPASS = 1 it is additionally forced to 0 when a same-cycle write to that address is forwarded, since the value is then available.
- a0 always reflects the stored register 10. It is not bypassed.
- Reset asserted mid-operation: pending busy bits are lost, and the core is required to flush with them.

Test Plan:
- Reset: drive writes with rst_n = 0, then deassert.
  -> all RD = 0, BUSY = 0, a0 = 0; no write takes effect.
- Basic write: WE0 = 1, AD_W0 = 10, WD0 = 32'hDEADBEEF; next cycle read AD_R port 0 = 10.
  -> RD0 = DEADBEEF and a0 = DEADBEEF.
- Bypass and conflict: in the same cycle, WE0 writes reg 5 = 32'h11 and WE1 writes reg 5 = 32'h22, while both read ports address 5.
  -> RD0 = RD1 = 32'h22 combinationally; the stored value is 32'h22 afterwards.
  -> With BYPASS = 0, both reads return the old value 0.
- Zero register: WE1 = 1, AD_W1 = 0, WD1 = 32'hFFFFFFFF; BUSY_SET with AD_BUSY = 0.
  -> RD for address 0 = 0; BUSY[0] = 0.
- Scoreboard lifecycle:
  - BUSY_SET with AD_BUSY = 7, and read port 1 addresses 7.
    -> BUSY[7] = 1 and RD_BUSY[1] = 1 from the next cycle.
  - Later, WE1 writes reg 7 = 32'h5.
    -> RD_BUSY[1] = 0 in that cycle (bypassed); BUSY[7] = 0 after the edge.
- Set/clear collision: WE0 writes reg 3 in the same cycle as BUSY_SET with AD_BUSY = 3.
  -> BUSY[3] = 1 after the edge, and reg 3 is updated.
  -> Then assert rst_n = 0 mid-cycle: BUSY clears immediately, asynchronously.
